// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg
//   Shared encodings for the multicycle MIPS control path: opcode constants,
//   FSM state encoding, and the ula_operation / alu_src_b / pc_source select
//   codes. The datapath and ula_control import the same definitions.
package mips_ctrl_pkg;

  // instruction[31:26]
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXECUTE   = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_ADDI_EXEC = 4'd10,
    S_ADDI_WB   = 4'd11
  } state_t;

  // ula_operation, consumed by ula_control
  localparam logic [1:0] ULA_ADD   = 2'b00;
  localparam logic [1:0] ULA_SUB   = 2'b01;
  localparam logic [1:0] ULA_FUNCT = 2'b10;

  // alu_src_b select
  localparam logic [1:0] ASB_REG_B   = 2'b00;
  localparam logic [1:0] ASB_FOUR    = 2'b01;
  localparam logic [1:0] ASB_SEXT    = 2'b10;
  localparam logic [1:0] ASB_SEXT_SH = 2'b11;

  // pc_source select
  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;

  function automatic logic is_legal_opcode(input logic [5:0] op);
    case (op)
      OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: is_legal_opcode = 1'b1;
      default:                                   is_legal_opcode = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mips_ctrl_outputs.sv
// mips_ctrl_outputs
//   Pure decoder from FSM state to datapath controls. Only FETCH looks at
//   i_mem_ready: the IR and PC are loaded on the cycle the fetch completes.
// Ports:
//   i_state, i_mem_ready          current state, memory handshake
//   o_pc_write .. o_reg_write     write strobes and 1-bit selects
//   o_alu_src_b, o_ula_operation, o_pc_source   2-bit selects
module mips_ctrl_outputs
  import mips_ctrl_pkg::*;
(
  input  state_t     i_state,
  input  logic       i_mem_ready,
  output logic       o_pc_write,
  output logic       o_pc_write_cond,
  output logic       o_i_or_d,
  output logic       o_mem_read,
  output logic       o_mem_write,
  output logic       o_ir_write,
  output logic       o_mem_to_reg,
  output logic       o_reg_dst,
  output logic       o_reg_write,
  output logic       o_alu_src_a,
  output logic [1:0] o_alu_src_b,
  output logic [1:0] o_ula_operation,
  output logic [1:0] o_pc_source
);

  always_comb begin
    o_pc_write      = 1'b0;
    o_pc_write_cond = 1'b0;
    o_i_or_d        = 1'b0;
    o_mem_read      = 1'b0;
    o_mem_write     = 1'b0;
    o_ir_write      = 1'b0;
    o_mem_to_reg    = 1'b0;
    o_reg_dst       = 1'b0;
    o_reg_write     = 1'b0;
    o_alu_src_a     = 1'b0;
    o_alu_src_b     = ASB_REG_B;
    o_ula_operation = ULA_ADD;
    o_pc_source     = PCS_ALU;
    case (i_state)
      S_FETCH: begin
        // PC+4 is computed every fetch cycle but only committed with the IR
        o_mem_read  = 1'b1;
        o_alu_src_b = ASB_FOUR;
        o_ir_write  = i_mem_ready;
        o_pc_write  = i_mem_ready;
      end
      S_DECODE: begin
        // speculative branch target into ALUOut
        o_alu_src_b = ASB_SEXT_SH;
      end
      S_MEM_ADDR, S_ADDI_EXEC: begin
        o_alu_src_a = 1'b1;
        o_alu_src_b = ASB_SEXT;
      end
      S_MEM_READ: begin
        o_mem_read = 1'b1;
        o_i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        o_reg_write  = 1'b1;
        o_mem_to_reg = 1'b1;
      end
      S_MEM_WRITE: begin
        o_mem_write = 1'b1;
        o_i_or_d    = 1'b1;
      end
      S_EXECUTE: begin
        o_alu_src_a     = 1'b1;
        o_ula_operation = ULA_FUNCT;
      end
      S_R_WB: begin
        o_reg_write = 1'b1;
        o_reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        o_alu_src_a     = 1'b1;
        o_ula_operation = ULA_SUB;
        o_pc_write_cond = 1'b1;
        o_pc_source     = PCS_ALUOUT;
      end
      S_JUMP: begin
        o_pc_write  = 1'b1;
        o_pc_source = PCS_JUMP;
      end
      S_ADDI_WB: begin
        o_reg_write = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_control.sv
// mips_multicycle_control
//   Moore FSM sequencing fetch/decode/execute/memory/write-back for the
//   multicycle MIPS datapath, plus a retired-instruction counter.
// Ports:
//   i_clock, i_reset_n (async, active-low), i_opcode (IR[31:26]), i_mem_ready
//   o_* datapath strobes/selects, o_illegal_op (DECODE pulse),
//   o_state (debug), o_instr_count (retired instructions, wraps)
module mips_multicycle_control
  import mips_ctrl_pkg::*;
(
  input  logic        i_clock,
  input  logic        i_reset_n,
  input  logic [5:0]  i_opcode,
  input  logic        i_mem_ready,
  output logic        o_pc_write,
  output logic        o_pc_write_cond,
  output logic        o_i_or_d,
  output logic        o_mem_read,
  output logic        o_mem_write,
  output logic        o_ir_write,
  output logic        o_mem_to_reg,
  output logic        o_reg_dst,
  output logic        o_reg_write,
  output logic        o_alu_src_a,
  output logic [1:0]  o_alu_src_b,
  output logic [1:0]  o_ula_operation,
  output logic [1:0]  o_pc_source,
  output logic        o_illegal_op,
  output logic [3:0]  o_state,
  output logic [31:0] o_instr_count
);

  state_t      r_state;
  state_t      w_next_state;
  logic [31:0] r_instr_count;
  logic        w_retire;

  logic w_pc_write, w_pc_write_cond, w_mem_write, w_ir_write, w_reg_write;

  mips_ctrl_outputs u_outputs (
    .i_state         (r_state),
    .i_mem_ready     (i_mem_ready),
    .o_pc_write      (w_pc_write),
    .o_pc_write_cond (w_pc_write_cond),
    .o_i_or_d        (o_i_or_d),
    .o_mem_read      (o_mem_read),
    .o_mem_write     (w_mem_write),
    .o_ir_write      (w_ir_write),
    .o_mem_to_reg    (o_mem_to_reg),
    .o_reg_dst       (o_reg_dst),
    .o_reg_write     (w_reg_write),
    .o_alu_src_a     (o_alu_src_a),
    .o_alu_src_b     (o_alu_src_b),
    .o_ula_operation (o_ula_operation),
    .o_pc_source     (o_pc_source)
  );

  // FETCH strobes depend on i_mem_ready, so gate every write strobe with
  // reset to keep the datapath quiet while reset is held.
  assign o_pc_write      = w_pc_write      & i_reset_n;
  assign o_pc_write_cond = w_pc_write_cond & i_reset_n;
  assign o_mem_write     = w_mem_write     & i_reset_n;
  assign o_ir_write      = w_ir_write      & i_reset_n;
  assign o_reg_write     = w_reg_write     & i_reset_n;

  assign o_illegal_op  = (r_state == S_DECODE) && !is_legal_opcode(i_opcode);
  assign o_state       = r_state;
  assign o_instr_count = r_instr_count;

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_FETCH:  if (i_mem_ready) w_next_state = S_DECODE;
      S_DECODE: begin
        case (i_opcode)
          OP_LW, OP_SW: w_next_state = S_MEM_ADDR;
          OP_R:         w_next_state = S_EXECUTE;
          OP_BEQ:       w_next_state = S_BRANCH;
          OP_J:         w_next_state = S_JUMP;
          OP_ADDI:      w_next_state = S_ADDI_EXEC;
          default:      w_next_state = S_FETCH;
        endcase
      end
      S_MEM_ADDR: begin
        if (i_opcode == OP_LW)      w_next_state = S_MEM_READ;
        else if (i_opcode == OP_SW) w_next_state = S_MEM_WRITE;
        else                        w_next_state = S_FETCH;
      end
      S_MEM_READ:  if (i_mem_ready) w_next_state = S_MEM_WB;
      S_MEM_WRITE: if (i_mem_ready) w_next_state = S_FETCH;
      S_EXECUTE:   w_next_state = S_R_WB;
      S_ADDI_EXEC: w_next_state = S_ADDI_WB;
      S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP, S_ADDI_WB: w_next_state = S_FETCH;
      default:     w_next_state = S_FETCH;
    endcase
  end

  // An instruction retires when the FSM re-enters FETCH; waiting in FETCH
  // for the memory does not count.
  assign w_retire = (r_state != S_FETCH) && (w_next_state == S_FETCH);

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state       <= S_FETCH;
      r_instr_count <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_retire) r_instr_count <= r_instr_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_mips_multicycle_control.sv
module tb_mips_multicycle_control;
  import mips_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  opcode;
  logic        mem_ready;
  logic        pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic        mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
  logic [1:0]  alu_src_b, ula_operation, pc_source;
  logic [3:0]  state;
  logic [31:0] instr_count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mips_multicycle_control dut (
    .i_clock         (clk),
    .i_reset_n       (rst_n),
    .i_opcode        (opcode),
    .i_mem_ready     (mem_ready),
    .o_pc_write      (pc_write),
    .o_pc_write_cond (pc_write_cond),
    .o_i_or_d        (i_or_d),
    .o_mem_read      (mem_read),
    .o_mem_write     (mem_write),
    .o_ir_write      (ir_write),
    .o_mem_to_reg    (mem_to_reg),
    .o_reg_dst       (reg_dst),
    .o_reg_write     (reg_write),
    .o_alu_src_a     (alu_src_a),
    .o_alu_src_b     (alu_src_b),
    .o_ula_operation (ula_operation),
    .o_pc_source     (pc_source),
    .o_illegal_op    (illegal_op),
    .o_state         (state),
    .o_instr_count   (instr_count)
  );

  // Control word bit order:
  // pcw pcwc iord mrd mwr irw m2r rdst rwr asa | asb[1:0] | ula[1:0] | psrc[1:0] | ill
  logic [16:0] ctrl;
  assign ctrl = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                 mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b,
                 ula_operation, pc_source, illegal_op};

  localparam logic [16:0] C_FETCH_RDY  = 17'b1_0_0_1_0_1_0_0_0_0_01_00_00_0;
  localparam logic [16:0] C_FETCH_WAIT = 17'b0_0_0_1_0_0_0_0_0_0_01_00_00_0;
  localparam logic [16:0] C_DECODE     = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_0;
  localparam logic [16:0] C_DECODE_ILL = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_1;
  localparam logic [16:0] C_MEM_ADDR   = 17'b0_0_0_0_0_0_0_0_0_1_10_00_00_0;
  localparam logic [16:0] C_MEM_READ   = 17'b0_0_1_1_0_0_0_0_0_0_00_00_00_0;
  localparam logic [16:0] C_MEM_WB     = 17'b0_0_0_0_0_0_1_0_1_0_00_00_00_0;
  localparam logic [16:0] C_MEM_WRITE  = 17'b0_0_1_0_1_0_0_0_0_0_00_00_00_0;
  localparam logic [16:0] C_EXECUTE    = 17'b0_0_0_0_0_0_0_0_0_1_00_10_00_0;
  localparam logic [16:0] C_R_WB       = 17'b0_0_0_0_0_0_0_1_1_0_00_00_00_0;
  localparam logic [16:0] C_BRANCH     = 17'b0_1_0_0_0_0_0_0_0_1_00_01_01_0;
  localparam logic [16:0] C_JUMP       = 17'b1_0_0_0_0_0_0_0_0_0_00_00_10_0;
  localparam logic [16:0] C_ADDI_EXEC  = 17'b0_0_0_0_0_0_0_0_0_1_10_00_00_0;
  localparam logic [16:0] C_ADDI_WB    = 17'b0_0_0_0_0_0_0_0_1_0_00_00_00_0;

  typedef struct {
    logic [5:0]  op;
    logic        rdy;
    state_t      exp_state;
    logic [16:0] exp_ctrl;
    logic [31:0] exp_cnt;
  } vec_t;

  vec_t vecs[34];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // R
    vecs[0]  = '{OP_R,    1'b1, S_FETCH,     C_FETCH_RDY,  32'd0};
    vecs[1]  = '{OP_R,    1'b1, S_DECODE,    C_DECODE,     32'd0};
    vecs[2]  = '{OP_R,    1'b1, S_EXECUTE,   C_EXECUTE,    32'd0};
    vecs[3]  = '{OP_R,    1'b1, S_R_WB,      C_R_WB,       32'd0};
    // LW, two wait cycles in MEM_READ
    vecs[4]  = '{OP_LW,   1'b1, S_FETCH,     C_FETCH_RDY,  32'd1};
    vecs[5]  = '{OP_LW,   1'b1, S_DECODE,    C_DECODE,     32'd1};
    vecs[6]  = '{OP_LW,   1'b1, S_MEM_ADDR,  C_MEM_ADDR,   32'd1};
    vecs[7]  = '{OP_LW,   1'b0, S_MEM_READ,  C_MEM_READ,   32'd1};
    vecs[8]  = '{OP_LW,   1'b0, S_MEM_READ,  C_MEM_READ,   32'd1};
    vecs[9]  = '{OP_LW,   1'b1, S_MEM_READ,  C_MEM_READ,   32'd1};
    vecs[10] = '{OP_LW,   1'b1, S_MEM_WB,    C_MEM_WB,     32'd1};
    // SW
    vecs[11] = '{OP_SW,   1'b1, S_FETCH,     C_FETCH_RDY,  32'd2};
    vecs[12] = '{OP_SW,   1'b1, S_DECODE,    C_DECODE,     32'd2};
    vecs[13] = '{OP_SW,   1'b1, S_MEM_ADDR,  C_MEM_ADDR,   32'd2};
    vecs[14] = '{OP_SW,   1'b1, S_MEM_WRITE, C_MEM_WRITE,  32'd2};
    // BEQ
    vecs[15] = '{OP_BEQ,  1'b1, S_FETCH,     C_FETCH_RDY,  32'd3};
    vecs[16] = '{OP_BEQ,  1'b1, S_DECODE,    C_DECODE,     32'd3};
    vecs[17] = '{OP_BEQ,  1'b1, S_BRANCH,    C_BRANCH,     32'd3};
    // J
    vecs[18] = '{OP_J,    1'b1, S_FETCH,     C_FETCH_RDY,  32'd4};
    vecs[19] = '{OP_J,    1'b1, S_DECODE,    C_DECODE,     32'd4};
    vecs[20] = '{OP_J,    1'b1, S_JUMP,      C_JUMP,       32'd4};
    // ADDI, one wait cycle in FETCH
    vecs[21] = '{OP_ADDI, 1'b0, S_FETCH,     C_FETCH_WAIT, 32'd5};
    vecs[22] = '{OP_ADDI, 1'b1, S_FETCH,     C_FETCH_RDY,  32'd5};
    vecs[23] = '{OP_ADDI, 1'b1, S_DECODE,    C_DECODE,     32'd5};
    vecs[24] = '{OP_ADDI, 1'b1, S_ADDI_EXEC, C_ADDI_EXEC,  32'd5};
    vecs[25] = '{OP_ADDI, 1'b1, S_ADDI_WB,   C_ADDI_WB,    32'd5};
    // illegal opcode
    vecs[26] = '{6'h3F,   1'b1, S_FETCH,     C_FETCH_RDY,  32'd6};
    vecs[27] = '{6'h3F,   1'b1, S_DECODE,    C_DECODE_ILL, 32'd6};
    // SW with one wait cycle in MEM_WRITE
    vecs[28] = '{OP_SW,   1'b1, S_FETCH,     C_FETCH_RDY,  32'd7};
    vecs[29] = '{OP_SW,   1'b1, S_DECODE,    C_DECODE,     32'd7};
    vecs[30] = '{OP_SW,   1'b1, S_MEM_ADDR,  C_MEM_ADDR,   32'd7};
    vecs[31] = '{OP_SW,   1'b0, S_MEM_WRITE, C_MEM_WRITE,  32'd7};
    vecs[32] = '{OP_SW,   1'b1, S_MEM_WRITE, C_MEM_WRITE,  32'd7};
    vecs[33] = '{OP_R,    1'b0, S_FETCH,     C_FETCH_WAIT, 32'd8};

    // Reset held 3 cycles with mem_ready high: strobes stay low
    rst_n = 1'b0; mem_ready = 1'b1; opcode = OP_R;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      check("reset_state", {28'd0, state}, {28'd0, S_FETCH});
      check("reset_ctrl", {15'd0, ctrl}, {15'd0, C_FETCH_WAIT});
      check("reset_count", instr_count, 32'd0);
    end
    rst_n = 1'b1;

    for (int i = 0; i < 34; i++) begin
      opcode = vecs[i].op; mem_ready = vecs[i].rdy;
      #1;
      check($sformatf("vec%0d_state", i), {28'd0, state}, {28'd0, vecs[i].exp_state});
      check($sformatf("vec%0d_ctrl", i), {15'd0, ctrl}, {15'd0, vecs[i].exp_ctrl});
      check($sformatf("vec%0d_count", i), instr_count, vecs[i].exp_cnt);
      @(negedge clk);
    end

    // LW abandoned by reset in MEM_WB
    opcode = OP_LW; mem_ready = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    check("lw_wb_state", {28'd0, state}, {28'd0, S_MEM_WB});
    check("lw_wb_regwrite", {31'd0, reg_write}, 32'd1);
    check("lw_wb_count", instr_count, 32'd8);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_regwrite", {31'd0, reg_write}, 32'd0);
    check("async_rst_state", {28'd0, state}, {28'd0, S_FETCH});
    check("async_rst_count", instr_count, 32'd0);
    @(negedge clk);
    rst_n = 1'b1; opcode = OP_J; mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("post_rst_j_state", {28'd0, state}, {28'd0, S_FETCH});
    check("post_rst_j_count", instr_count, 32'd1);

    // Counter wrap
    mem_ready = 1'b0;
    @(negedge clk);
    force dut.r_instr_count = 32'hFFFF_FFFF;
    #1 release dut.r_instr_count;
    #1;
    check("preload_count", instr_count, 32'hFFFF_FFFF);
    opcode = OP_BEQ; mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("wrap_state", {28'd0, state}, {28'd0, S_FETCH});
    check("wrap_count", instr_count, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
